// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and FSM state type for the ALU control sequencer.
package alu_ctrl_pkg;

  // Opcode encodings
  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_ADDI  = 1;
  localparam int unsigned OP_SUBI  = 2;
  localparam int unsigned OP_SLTI  = 3;

  // R-type func encodings
  localparam int unsigned FN_ADD = 0;
  localparam int unsigned FN_SUB = 1;
  localparam int unsigned FN_SLT = 3;
  localparam int unsigned FN_AND = 4;
  localparam int unsigned FN_OR  = 5;
  localparam int unsigned FN_NOT = 6;
  localparam int unsigned FN_XOR = 7;
  localparam int unsigned FN_MUL = 8;

  // ALU operation codes
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_SLT = 3;
  localparam int unsigned ALU_AND = 4;
  localparam int unsigned ALU_OR  = 5;
  localparam int unsigned ALU_NOT = 6;
  localparam int unsigned ALU_XOR = 7;
  localparam int unsigned ALU_MUL = 8;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    HOLD
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/func decoder; undefined encodings yield code 0 with illegal set.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 3,
  parameter int unsigned FN_W   = 4,
  parameter int unsigned CODE_W = 4
) (
  input  logic [OP_W-1:0]   i_opcode,
  input  logic [FN_W-1:0]   i_func,
  output logic [CODE_W-1:0] o_code,
  output logic              o_illegal,
  output logic              o_multi
);

  // Full decode with defaults first so every path is assigned
  always_comb begin
    o_code    = '0;
    o_illegal = 1'b0;
    o_multi   = 1'b0;
    case (i_opcode)
      OP_W'(OP_RTYPE): begin
        case (i_func)
          FN_W'(FN_ADD): o_code = CODE_W'(ALU_ADD);
          FN_W'(FN_SUB): o_code = CODE_W'(ALU_SUB);
          FN_W'(FN_SLT): o_code = CODE_W'(ALU_SLT);
          FN_W'(FN_AND): o_code = CODE_W'(ALU_AND);
          FN_W'(FN_OR):  o_code = CODE_W'(ALU_OR);
          FN_W'(FN_NOT): o_code = CODE_W'(ALU_NOT);
          FN_W'(FN_XOR): o_code = CODE_W'(ALU_XOR);
          FN_W'(FN_MUL): begin
            o_code  = CODE_W'(ALU_MUL);
            o_multi = 1'b1;
          end
          default:       o_illegal = 1'b1;
        endcase
      end
      OP_W'(OP_ADDI): o_code = CODE_W'(ALU_ADD);
      OP_W'(OP_SUBI): o_code = CODE_W'(ALU_SUB);
      OP_W'(OP_SLTI): o_code = CODE_W'(ALU_SLT);
      default:        o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU control sequencer: decodes opcode/func, steps multi-cycle ops, holds result until taken.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = 3,
  parameter int unsigned FN_W       = 4,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned MUL_CYCLES = 16,
  parameter int unsigned CNT_W      = $clog2(MUL_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FN_W-1:0]   func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] alu_code,
  output logic              illegal,
  output logic              multi,
  output logic              step_en,
  output logic [CNT_W-1:0]  step_cnt
);

  state_t              r_state;
  logic                r_out_valid;
  logic [CODE_W-1:0]   r_alu_code;
  logic                r_illegal;
  logic                r_multi;
  logic                r_step_en;
  logic [CNT_W-1:0]    r_step_cnt;

  logic [CODE_W-1:0]   w_code;
  logic                w_illegal;
  logic                w_multi;
  logic                w_accept;

  alu_decode #(
    .OP_W   (OP_W),
    .FN_W   (FN_W),
    .CODE_W (CODE_W)
  ) u_decode (
    .i_opcode  (opcode),
    .i_func    (func),
    .o_code    (w_code),
    .o_illegal (w_illegal),
    .o_multi   (w_multi)
  );

  // Ready when idle, or when the held result is being taken this cycle
  always_comb begin
    in_ready = !rst && ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
  end

  assign w_accept = in_valid && in_ready;

  // FSM, result registers and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_alu_code  <= '0;
      r_illegal   <= 1'b0;
      r_multi     <= 1'b0;
      r_step_en   <= 1'b0;
      r_step_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            r_alu_code <= w_code;
            r_illegal  <= w_illegal;
            r_multi    <= w_multi;
            r_step_cnt <= '0;
            if (w_multi) begin
              r_state     <= ITER;
              r_step_en   <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= HOLD;
              r_step_en   <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end else if ((r_state == HOLD) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ITER: begin
          // Last step: counter holds at MUL_CYCLES-1 and the result is presented
          if (r_step_cnt == CNT_W'(MUL_CYCLES - 1)) begin
            r_state     <= HOLD;
            r_step_en   <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_step_cnt <= r_step_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_step_en   <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign alu_code  = r_alu_code;
  assign illegal   = r_illegal;
  assign multi     = r_multi;
  assign step_en   = r_step_en;
  assign step_cnt  = r_step_cnt;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq with hand-computed expectations.
module tb_alu_ctrl_seq;

  localparam int unsigned OP_W       = 3;
  localparam int unsigned FN_W       = 4;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned MUL_CYCLES = 16;
  localparam int unsigned CNT_W      = $clog2(MUL_CYCLES + 1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   opcode;
  logic [FN_W-1:0]   func;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] alu_code;
  logic              illegal;
  logic              multi;
  logic              step_en;
  logic [CNT_W-1:0]  step_cnt;

  int n_vec;
  int n_err;

  alu_ctrl_seq #(
    .OP_W       (OP_W),
    .FN_W       (FN_W),
    .CODE_W     (CODE_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_code  (alu_code),
    .illegal   (illegal),
    .multi     (multi),
    .step_en   (step_en),
    .step_cnt  (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int unsigned op, input int unsigned fn);
    in_valid = v;
    opcode   = OP_W'(op);
    func     = FN_W'(fn);
    #1;
  endtask

  // Decode table: {opcode, func, expected code, expected illegal}, all single-cycle
  typedef struct {
    int unsigned op;
    int unsigned fn;
    int unsigned code;
    int unsigned ill;
  } vec_t;

  vec_t tbl [14];

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0]  = '{0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0};
    tbl[2]  = '{0, 3, 3, 0};
    tbl[3]  = '{0, 4, 4, 0};
    tbl[4]  = '{0, 6, 6, 0};
    tbl[5]  = '{0, 7, 7, 0};
    tbl[6]  = '{1, 9, 0, 0};
    tbl[7]  = '{2, 0, 1, 0};
    tbl[8]  = '{3, 15, 3, 0};
    tbl[9]  = '{0, 2, 0, 1};
    tbl[10] = '{0, 15, 0, 1};
    tbl[11] = '{4, 0, 0, 1};
    tbl[12] = '{7, 8, 0, 1};
    tbl[13] = '{5, 3, 0, 1};

    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 0, 0);
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu_code", 32'(alu_code), 0);
    check("rst_step_en", 32'(step_en), 0);
    check("rst_step_cnt", 32'(step_cnt), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Single-cycle OR
    out_ready = 1'b1;
    drive(1'b1, 0, 5);
    tick();
    drive(1'b0, 0, 0);
    check("or_valid", 32'(out_valid), 1);
    check("or_code", 32'(alu_code), 5);
    check("or_illegal", 32'(illegal), 0);
    check("or_multi", 32'(multi), 0);
    check("hold_take_ready", 32'(in_ready), 1);
    tick();
    check("or_drain", 32'(out_valid), 0);

    // Multiply: 16 iteration cycles then result
    drive(1'b1, 0, 8);
    tick();
    drive(1'b0, 0, 0);
    for (int i = 0; i < int'(MUL_CYCLES); i++) begin
      check("mul_step_en", 32'(step_en), 1);
      check("mul_step_cnt", 32'(step_cnt), 32'(i));
      check("mul_in_ready", 32'(in_ready), 0);
      check("mul_no_valid", 32'(out_valid), 0);
      tick();
    end
    check("mul_valid", 32'(out_valid), 1);
    check("mul_code", 32'(alu_code), 8);
    check("mul_multi", 32'(multi), 1);
    check("mul_step_off", 32'(step_en), 0);
    check("mul_cnt_hold", 32'(step_cnt), MUL_CYCLES - 1);
    tick();
    check("mul_drain", 32'(out_valid), 0);

    // Illegal encodings back-to-back
    drive(1'b1, 0, 2);
    tick();
    check("ill_fn_valid", 32'(out_valid), 1);
    check("ill_fn_code", 32'(alu_code), 0);
    check("ill_fn_flag", 32'(illegal), 1);
    drive(1'b1, 6, 0);
    tick();
    drive(1'b0, 0, 0);
    check("ill_op_valid", 32'(out_valid), 1);
    check("ill_op_code", 32'(alu_code), 0);
    check("ill_op_flag", 32'(illegal), 1);
    check("ill_op_multi", 32'(multi), 0);
    tick();

    // Backpressure on subi, then take with same-cycle addi issue
    out_ready = 1'b0;
    drive(1'b1, 2, 0);
    tick();
    drive(1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_code", 32'(alu_code), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 1, 0);
    check("bp_take_ready", 32'(in_ready), 1);
    tick();
    drive(1'b0, 0, 0);
    check("b2b_valid", 32'(out_valid), 1);
    check("b2b_code", 32'(alu_code), 0);
    check("b2b_illegal", 32'(illegal), 0);
    tick();

    // Stream add, sub, xor
    drive(1'b1, 0, 0);
    tick();
    check("s_add_valid", 32'(out_valid), 1);
    check("s_add_code", 32'(alu_code), 0);
    drive(1'b1, 0, 1);
    tick();
    check("s_sub_valid", 32'(out_valid), 1);
    check("s_sub_code", 32'(alu_code), 1);
    drive(1'b1, 0, 7);
    tick();
    drive(1'b0, 0, 0);
    check("s_xor_valid", 32'(out_valid), 1);
    check("s_xor_code", 32'(alu_code), 7);
    tick();
    check("s_drain", 32'(out_valid), 0);

    // Decode table streamed back-to-back
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].fn);
      tick();
      check("tbl_valid", 32'(out_valid), 1);
      check("tbl_code", 32'(alu_code), tbl[i].code);
      check("tbl_illegal", 32'(illegal), tbl[i].ill);
      check("tbl_multi", 32'(multi), 0);
    end
    drive(1'b0, 0, 0);
    tick();

    // Reset mid-multiply discards the operation
    drive(1'b1, 0, 8);
    tick();
    drive(1'b0, 0, 0);
    for (int i = 0; i < 7; i++) tick();
    check("abort_cnt7", 32'(step_cnt), 7);
    rst = 1'b1;
    tick();
    check("abort_step_en", 32'(step_en), 0);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_cnt", 32'(step_cnt), 0);
    check("abort_multi", 32'(multi), 0);
    check("abort_code", 32'(alu_code), 0);
    rst = 1'b0;
    #1;
    check("abort_idle_ready", 32'(in_ready), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_result", 32'(out_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
